// File: rtl/sm_mcu_pkg.sv
// Shared register addresses and edge-select encodings for the SM_MCU LCD PIO blocks.
package sm_mcu_pkg;

    localparam logic [1:0] ADDR_DATA   = 2'd0;
    localparam logic [1:0] ADDR_RSVD   = 2'd1;
    localparam logic [1:0] ADDR_IRQMSK = 2'd2;
    localparam logic [1:0] ADDR_EDGCAP = 2'd3;

    localparam int EDGE_RISE = 0;
    localparam int EDGE_FALL = 1;
    localparam int EDGE_ANY  = 2;

    // Clocks from reset release until the edge detector sees settled history.
    function automatic int prime_len(input int sync_stages);
        return sync_stages + 1;
    endfunction

endpackage

// File: rtl/sm_mcu_sync_edge.sv
// Per-pin synchroniser chain, one-clock history register and edge select.
module sm_mcu_sync_edge
    import sm_mcu_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_port,
    output logic [WIDTH-1:0] sync_o,
    output logic [WIDTH-1:0] edge_o
);

    logic [WIDTH-1:0] sync_q [SYNC_STAGES];
    logic [WIDTH-1:0] sync_d [SYNC_STAGES];
    logic [WIDTH-1:0] prev_q;
    logic [WIDTH-1:0] prev_d;
    logic [WIDTH-1:0] s;

    assign s      = sync_q[SYNC_STAGES-1];
    assign sync_o = s;

    always_comb begin
        sync_d[0] = in_port;
        for (int i = 1; i < SYNC_STAGES; i++) begin
            sync_d[i] = sync_q[i-1];
        end
        prev_d = s;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < SYNC_STAGES; i++) begin
                sync_q[i] <= '0;
            end
            prev_q <= '0;
        end else begin
            sync_q <= sync_d;
            prev_q <= prev_d;
        end
    end

    always_comb begin
        edge_o = s & ~prev_q;
        if (EDGE_TYPE == EDGE_FALL) begin
            edge_o = ~s & prev_q;
        end else if (EDGE_TYPE == EDGE_ANY) begin
            edge_o = s ^ prev_q;
        end
    end

endmodule

// File: rtl/sm_mcu_lcd_te_pio.sv
// Avalon-MM input PIO for TFT status pins: sync, sticky edge capture, masked level irq.
module sm_mcu_lcd_te_pio
    import sm_mcu_pkg::*;
#(
    parameter int WIDTH       = 1,
    parameter int SYNC_STAGES = 2,
    parameter int EDGE_TYPE   = EDGE_RISE
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [1:0]       address,
    input  logic             chipselect,
    input  logic             write_n,
    input  logic [31:0]      writedata,
    input  logic [WIDTH-1:0] in_port,
    output logic [31:0]      readdata,
    output logic             irq
);

    localparam int         PRIME_CNT = prime_len(SYNC_STAGES);
    localparam logic [2:0] PRIME_END = 3'(PRIME_CNT);

    logic [WIDTH-1:0] sync_v;
    logic [WIDTH-1:0] edge_v;
    logic [WIDTH-1:0] irqmsk_q, irqmsk_d;
    logic [WIDTH-1:0] edgcap_q, edgcap_d;
    logic [WIDTH-1:0] clr_v;
    logic [2:0]       prime_q, prime_d;
    logic [31:0]      readdata_q, readdata_d;
    logic             irq_q, irq_d;
    logic             primed;
    logic             wr_en;
    logic             unused_wdata;

    assign unused_wdata = ^writedata;

    sm_mcu_sync_edge #(
        .WIDTH       (WIDTH),
        .SYNC_STAGES (SYNC_STAGES),
        .EDGE_TYPE   (EDGE_TYPE)
    ) u_sync_edge (
        .clk     (clk),
        .reset   (reset),
        .in_port (in_port),
        .sync_o  (sync_v),
        .edge_o  (edge_v)
    );

    // Bus: a write is chipselect & ~write_n sampled on one edge, no wait state;
    // reads have fixed 1-clk latency and reflect state before any same-edge write.
    assign wr_en  = chipselect & ~write_n;
    assign primed = (prime_q == PRIME_END);

    always_comb begin
        prime_d  = primed ? prime_q : prime_q + 3'd1;
        irqmsk_d = irqmsk_q;
        clr_v    = '0;
        if (wr_en && address == ADDR_IRQMSK) begin
            irqmsk_d = writedata[WIDTH-1:0];
        end
        if (wr_en && address == ADDR_EDGCAP) begin
            clr_v = writedata[WIDTH-1:0];
        end
        // Set after clear so a coincident edge is never lost.
        edgcap_d = (edgcap_q & ~clr_v) | (primed ? edge_v : '0);
        irq_d    = |(edgcap_q & irqmsk_q);

        readdata_d = '0;
        case (address)
            ADDR_DATA:   readdata_d[WIDTH-1:0] = sync_v;
            ADDR_IRQMSK: readdata_d[WIDTH-1:0] = irqmsk_q;
            ADDR_EDGCAP: readdata_d[WIDTH-1:0] = edgcap_q;
            default:     readdata_d = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            prime_q    <= '0;
            irqmsk_q   <= '0;
            edgcap_q   <= '0;
            readdata_q <= '0;
            irq_q      <= 1'b0;
        end else begin
            prime_q    <= prime_d;
            irqmsk_q   <= irqmsk_d;
            edgcap_q   <= edgcap_d;
            readdata_q <= readdata_d;
            irq_q      <= irq_d;
        end
    end

    assign readdata = readdata_q;
    assign irq      = irq_q;

endmodule
